// File: rtl/iob_im_obj_render.sv
// Sprite renderer: CPU-programmed rectangles drawn over a background colour, double-buffered per frame.
// Define IOB_IM_COLLISION_EN to build the sticky per-object overlap (COLL) register.
module iob_im_obj_render #(
  parameter int N_OBJ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int RGB_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iob_avalid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_rvalid,
  output logic                iob_ready,
  input  logic [9:0]          im_pixel_x,
  input  logic [9:0]          im_pixel_y,
  input  logic                im_pixel_valid,
  input  logic                im_frame_start,
  input  logic [31:0]         im_sw_input,
  output logic [RGB_W-1:0]    im_rgb,
  output logic                im_rgb_valid
);

  // Handshake: a request is accepted on any edge where iob_avalid && iob_ready;
  // its response (iob_rvalid, iob_rdata) is presented for exactly the next cycle.
  logic accept, wr_en, upd_act;
  assign iob_ready = ~rst;
  assign accept    = iob_avalid & ~rst;
  assign wr_en     = accept & (|iob_wstrb);

  logic unused_wdata;
  assign unused_wdata = ^iob_wdata[DATA_W-1:21];

  logic             ctrl_bypass;
  logic [RGB_W-1:0] bg_pend, bg_act;
  logic [20:0]      loc_pend  [N_OBJ];
  logic [15:0]      size_pend [N_OBJ];
  logic [RGB_W-1:0] col_pend  [N_OBJ];
  logic [20:0]      loc_act   [N_OBJ];
  logic [15:0]      size_act  [N_OBJ];
  logic [RGB_W-1:0] col_act   [N_OBJ];

  // A write landing on the frame-copy edge must not be lost by the copy.
  assign upd_act = ctrl_bypass | im_frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_bypass <= 1'b0;
      bg_pend     <= '0;
      bg_act      <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        loc_pend[i]  <= '0;
        size_pend[i] <= '0;
        col_pend[i]  <= '0;
        loc_act[i]   <= '0;
        size_act[i]  <= '0;
        col_act[i]   <= '0;
      end
    end else begin
      if (im_frame_start) begin
        bg_act <= bg_pend;
        for (int i = 0; i < N_OBJ; i++) begin
          loc_act[i]  <= loc_pend[i];
          size_act[i] <= size_pend[i];
          col_act[i]  <= col_pend[i];
        end
      end
      if (wr_en && iob_addr == ADDR_W'(0)) ctrl_bypass <= iob_wdata[0];
      if (wr_en && iob_addr == ADDR_W'(1)) begin
        bg_pend <= iob_wdata[RGB_W-1:0];
        if (upd_act) bg_act <= iob_wdata[RGB_W-1:0];
      end
      for (int i = 0; i < N_OBJ; i++) begin
        if (wr_en && iob_addr == ADDR_W'(4 + 4 * i)) begin
          loc_pend[i] <= iob_wdata[20:0];
          if (upd_act) loc_act[i] <= iob_wdata[20:0];
        end
        if (wr_en && iob_addr == ADDR_W'(5 + 4 * i)) begin
          size_pend[i] <= iob_wdata[15:0];
          if (upd_act) size_act[i] <= iob_wdata[15:0];
        end
        if (wr_en && iob_addr == ADDR_W'(6 + 4 * i)) begin
          col_pend[i] <= iob_wdata[RGB_W-1:0];
          if (upd_act) col_act[i] <= iob_wdata[RGB_W-1:0];
        end
      end
    end
  end

  // Hit test at 11 bits so objects near screen edges never wrap around.
  logic [N_OBJ-1:0] hit;
  logic [RGB_W-1:0] pix_rgb;

  always_comb begin
    hit     = '0;
    pix_rgb = bg_act;
    for (int i = 0; i < N_OBJ; i++) begin
      hit[i] = loc_act[i][20]
        && (({1'b0, im_pixel_x} + {3'b0, size_act[i][7:0]})  >= {1'b0, loc_act[i][9:0]})
        && ({1'b0, im_pixel_x} <= ({1'b0, loc_act[i][9:0]}   + {3'b0, size_act[i][7:0]}))
        && (({1'b0, im_pixel_y} + {3'b0, size_act[i][15:8]}) >= {1'b0, loc_act[i][19:10]})
        && ({1'b0, im_pixel_y} <= ({1'b0, loc_act[i][19:10]} + {3'b0, size_act[i][15:8]}));
    end
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) pix_rgb = col_act[i];
    end
  end

`ifdef IOB_IM_COLLISION_EN
  logic [N_OBJ-1:0] coll, coll_set, coll_clr;
  logic             multi_hit;

  // More than one bit set in hit <=> clearing the lowest set bit leaves something.
  assign multi_hit = |(hit & (hit - N_OBJ'(1)));
  assign coll_set  = (im_pixel_valid && multi_hit) ? hit : '0;
  assign coll_clr  = (wr_en && iob_addr == ADDR_W'(3)) ? iob_wdata[N_OBJ-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) coll <= '0;
    else     coll <= (coll & ~coll_clr) | coll_set;
  end
`endif

  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (iob_addr == ADDR_W'(0)) rd_val = DATA_W'(ctrl_bypass);
    if (iob_addr == ADDR_W'(1)) rd_val = DATA_W'(bg_pend);
    if (iob_addr == ADDR_W'(2)) rd_val = DATA_W'(im_sw_input);
`ifdef IOB_IM_COLLISION_EN
    if (iob_addr == ADDR_W'(3)) rd_val = DATA_W'(coll);
`endif
    for (int i = 0; i < N_OBJ; i++) begin
      if (iob_addr == ADDR_W'(4 + 4 * i)) rd_val = DATA_W'(loc_pend[i]);
      if (iob_addr == ADDR_W'(5 + 4 * i)) rd_val = DATA_W'(size_pend[i]);
      if (iob_addr == ADDR_W'(6 + 4 * i)) rd_val = DATA_W'(col_pend[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iob_rvalid <= 1'b0;
      iob_rdata  <= '0;
    end else begin
      iob_rvalid <= accept;
      iob_rdata  <= (accept && !wr_en) ? rd_val : '0;
    end
  end

  logic             s1_valid;
  logic [RGB_W-1:0] s1_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_rgb       <= '0;
      im_rgb_valid <= 1'b0;
      im_rgb       <= '0;
    end else begin
      s1_valid     <= im_pixel_valid;
      s1_rgb       <= im_pixel_valid ? pix_rgb : '0;
      im_rgb_valid <= s1_valid;
      im_rgb       <= s1_valid ? s1_rgb : '0;
    end
  end

endmodule

// File: tb/tb_iob_im_obj_render.sv
// Randomized + directed bench for iob_im_obj_render against a frame-level reference model.
module tb_iob_im_obj_render;
  localparam int N_OBJ = 3, DATA_W = 32, ADDR_W = 6, RGB_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              iob_avalid = 1'b0;
  logic [ADDR_W-1:0] iob_addr = '0;
  logic [DATA_W-1:0] iob_wdata = '0;
  logic [3:0]        iob_wstrb = '0;
  logic [DATA_W-1:0] iob_rdata;
  logic              iob_rvalid, iob_ready;
  logic [9:0]        im_pixel_x = '0, im_pixel_y = '0;
  logic              im_pixel_valid = 1'b0, im_frame_start = 1'b0;
  logic [31:0]       im_sw_input = '0;
  logic [RGB_W-1:0]  im_rgb;
  logic              im_rgb_valid;

  iob_im_obj_render #(.N_OBJ(N_OBJ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RGB_W(RGB_W)) dut (
    .clk(clk), .rst(rst),
    .iob_avalid(iob_avalid), .iob_addr(iob_addr), .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb),
    .iob_rdata(iob_rdata), .iob_rvalid(iob_rvalid), .iob_ready(iob_ready),
    .im_pixel_x(im_pixel_x), .im_pixel_y(im_pixel_y), .im_pixel_valid(im_pixel_valid),
    .im_frame_start(im_frame_start), .im_sw_input(im_sw_input),
    .im_rgb(im_rgb), .im_rgb_valid(im_rgb_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending and active register images, sticky collision bits.
  logic [20:0]      m_loc_p [N_OBJ], m_loc_a [N_OBJ];
  logic [15:0]      m_size_p[N_OBJ], m_size_a[N_OBJ];
  logic [RGB_W-1:0] m_col_p [N_OBJ], m_col_a [N_OBJ];
  logic [RGB_W-1:0] m_bg_p, m_bg_a;
  logic             m_bypass;
  logic [N_OBJ-1:0] m_coll;
  logic [12:0]      exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < N_OBJ; i++) begin
      m_loc_p[i] = '0; m_loc_a[i] = '0; m_size_p[i] = '0;
      m_size_a[i] = '0; m_col_p[i] = '0; m_col_a[i] = '0;
    end
    m_bg_p = '0; m_bg_a = '0; m_bypass = 1'b0; m_coll = '0;
  endtask

  function automatic logic [N_OBJ-1:0] hits_of(int px, int py);
    logic [N_OBJ-1:0] h = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      int ox = m_loc_a[i][9:0];
      int oy = m_loc_a[i][19:10];
      int hx = m_size_a[i][7:0];
      int hy = m_size_a[i][15:8];
      h[i] = m_loc_a[i][20] && (px + hx >= ox) && (px <= ox + hx) && (py + hy >= oy) && (py <= oy + hy);
    end
    return h;
  endfunction

  function automatic logic [RGB_W-1:0] render(logic [N_OBJ-1:0] h);
    for (int i = 0; i < N_OBJ; i++) if (h[i]) return m_col_a[i];
    return m_bg_a;
  endfunction

  function automatic logic [31:0] read_model(int a);
    if (a == 0) return 32'(m_bypass);
    if (a == 1) return 32'(m_bg_p);
    if (a == 2) return im_sw_input;
`ifdef IOB_IM_COLLISION_EN
    if (a == 3) return 32'(m_coll);
`endif
    if (a >= 4 && (a - 4) / 4 < N_OBJ) begin
      case ((a - 4) % 4)
        0: return 32'(m_loc_p[(a - 4) / 4]);
        1: return 32'(m_size_p[(a - 4) / 4]);
        2: return 32'(m_col_p[(a - 4) / 4]);
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_write(int a, logic [31:0] d, logic copy);
    logic act;
    int i;
    act = m_bypass || copy;
    if (a == 0) m_bypass = d[0];
    if (a == 1) begin m_bg_p = d[RGB_W-1:0]; if (act) m_bg_a = d[RGB_W-1:0]; end
    if (a == 3) m_coll = m_coll & ~d[N_OBJ-1:0];
    if (a >= 4 && (a - 4) / 4 < N_OBJ) begin
      i = (a - 4) / 4;
      case ((a - 4) % 4)
        0: begin m_loc_p[i]  = d[20:0];      if (act) m_loc_a[i]  = d[20:0];      end
        1: begin m_size_p[i] = d[15:0];      if (act) m_size_a[i] = d[15:0];      end
        2: begin m_col_p[i]  = d[RGB_W-1:0]; if (act) m_col_a[i]  = d[RGB_W-1:0]; end
        default: ;
      endcase
    end
  endtask

  // Scoreboard: one output sample per edge, compared against the pixel seen one edge before.
  logic [12:0]      mon_exp;
  logic [N_OBJ-1:0] mon_hit;

  always @(posedge clk) begin
    #1;
    check("ready", 32'(iob_ready), 32'(!rst));
    if (rst) begin
      check("rst_rgb", {im_rgb_valid, im_rgb}, 32'h0);
      check("rst_rvalid", 32'(iob_rvalid), 32'h0);
      check("rst_rdata", iob_rdata, 32'h0);
      exp_q.delete();
      exp_q.push_back(13'h0);
      model_reset();
    end else begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("pixel", {im_rgb_valid, im_rgb}, 32'(mon_exp));
      end
      check("rvalid", 32'(iob_rvalid), 32'(iob_avalid));
      mon_hit = hits_of(int'(im_pixel_x), int'(im_pixel_y));
      exp_q.push_back(im_pixel_valid ? {1'b1, render(mon_hit)} : 13'h0);
      if (im_frame_start) begin
        m_bg_a = m_bg_p;
        for (int i = 0; i < N_OBJ; i++) begin
          m_loc_a[i] = m_loc_p[i]; m_size_a[i] = m_size_p[i]; m_col_a[i] = m_col_p[i];
        end
      end
      if (iob_avalid && iob_wstrb != 4'h0) model_write(int'(iob_addr), iob_wdata, im_frame_start);
`ifdef IOB_IM_COLLISION_EN
      if (im_pixel_valid && $countones(mon_hit) >= 2) m_coll = m_coll | mon_hit;
`endif
    end
  end

  // Drivers: inputs change on the falling edge only.
  task automatic cpu_write(int a, logic [31:0] d);
    @(negedge clk);
    iob_avalid = 1'b1; iob_addr = ADDR_W'(a); iob_wdata = d; iob_wstrb = 4'hF;
    @(negedge clk);
    iob_avalid = 1'b0; iob_wstrb = 4'h0;
  endtask

  task automatic cpu_read(int a, output logic [31:0] d);
    logic [31:0] e;
    @(negedge clk);
    iob_avalid = 1'b1; iob_addr = ADDR_W'(a); iob_wstrb = 4'h0;
    e = read_model(a);
    @(negedge clk);
    iob_avalid = 1'b0;
    check("read_rvalid", 32'(iob_rvalid), 32'h1);
    check("read_model", iob_rdata, e);
    d = iob_rdata;
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    im_pixel_valid = 1'b0; im_frame_start = 1'b1;
    @(negedge clk);
    im_frame_start = 1'b0;
  endtask

  task automatic frame_with_write(int a, logic [31:0] d);
    @(negedge clk);
    im_pixel_valid = 1'b0; im_frame_start = 1'b1;
    iob_avalid = 1'b1; iob_addr = ADDR_W'(a); iob_wdata = d; iob_wstrb = 4'hF;
    @(negedge clk);
    im_frame_start = 1'b0; iob_avalid = 1'b0; iob_wstrb = 4'h0;
  endtask

  task automatic pixel(int x, int y, logic v);
    @(negedge clk);
    im_pixel_x = 10'(x); im_pixel_y = 10'(y); im_pixel_valid = v;
  endtask

  // Directed pixel with a hard-coded expected colour, checked two cycles later.
  task automatic directed_pixel(input string tag, int x, int y, logic [RGB_W-1:0] exp);
    pixel(x, y, 1'b1);
    @(negedge clk);
    im_pixel_valid = 1'b0;
    @(negedge clk);
    check(tag, {im_rgb_valid, im_rgb}, {19'h0, 1'b1, exp});
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      im_pixel_valid = 1'b0;
    end
  endtask

  localparam logic [31:0] EN = 32'h0010_0000;

  logic [31:0] rd;
  int          op, a, obj, fld;
  logic [31:0] w;

  initial begin
    model_reset();
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    im_sw_input = 32'hA5A5_0F0F;
    cpu_read(2, rd);
    check("sw_input", rd, 32'hA5A5_0F0F);

    cpu_write(4, EN | (100 << 10) | 100);
    cpu_write(5, 32'h0303);
    cpu_write(6, 32'hFFF);
    cpu_write(1, 32'h123);
    frame_pulse();
    directed_pixel("obj0_corner_in", 97, 103, 12'hFFF);
    directed_pixel("obj0_left_out", 96, 100, 12'h123);

    cpu_write(4, EN | (100 << 10) | 300);
    cpu_read(4, rd);
    check("loc_readback_pending", rd, EN | (100 << 10) | 300);
    directed_pixel("shadow_hold", 97, 103, 12'hFFF);
    frame_pulse();
    directed_pixel("shadow_old_gone", 97, 103, 12'h123);
    directed_pixel("shadow_new_pos", 300, 100, 12'hFFF);

    cpu_write(4, EN | (200 << 10) | 200);
    cpu_write(6, 32'hF00);
    cpu_write(8, EN | (200 << 10) | 202);
    cpu_write(9, 32'h0303);
    cpu_write(10, 32'h0F0);
    frame_pulse();
    directed_pixel("overlap_priority", 200, 200, 12'hF00);
    directed_pixel("obj1_only", 205, 200, 12'h0F0);
    cpu_read(3, rd);
`ifdef IOB_IM_COLLISION_EN
    check("coll_set", rd, 32'h3);
`else
    check("coll_absent", rd, 32'h0);
`endif
    cpu_write(3, 32'h1);
    cpu_read(3, rd);
`ifdef IOB_IM_COLLISION_EN
    check("coll_w1c", rd, 32'h2);
`else
    check("coll_absent_w1c", rd, 32'h0);
`endif

    cpu_write(12, EN | (500 << 10) | 1);
    cpu_write(13, 32'h0303);
    cpu_write(14, 32'h00F);
    frame_pulse();
    directed_pixel("left_edge_in", 0, 500, 12'h00F);
    directed_pixel("no_wrap_out", 1020, 500, 12'h123);

    cpu_write(0, 32'h1);
    cpu_write(4, EN | (600 << 10) | 600);
    directed_pixel("bypass_live", 600, 600, 12'hF00);
    cpu_write(0, 32'h0);

    frame_with_write(6, 32'hABC);
    directed_pixel("write_on_copy", 600, 600, 12'hABC);
    cpu_read(6, rd);
    check("write_on_copy_rd", rd, 32'hABC);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        obj = $urandom_range(0, N_OBJ - 1);
        fld = $urandom_range(0, 2);
        w = $urandom();
        if (fld == 0) w = (32'($urandom_range(0, 5) != 0) << 20) | (32'($urandom_range(0, 40)) << 10)
                          | 32'($urandom_range(0, 40)) | (w & 32'hFFE0_0000);
        if (fld == 1) w = (w & 32'hFFFF_0000) | (32'($urandom_range(0, 12)) << 8) | 32'($urandom_range(0, 12));
        cpu_write(4 + 4 * obj + fld, w);
      end else if (op == 3) begin
        cpu_write(1, $urandom());
      end else if (op == 4) begin
        frame_pulse();
      end else if (op <= 7) begin
        repeat (8) pixel($urandom_range(0, 50), $urandom_range(0, 50), 1'($urandom_range(0, 3) != 0));
        if ($urandom_range(0, 7) == 0) pixel(1023 - $urandom_range(0, 8), $urandom_range(0, 50), 1'b1);
        idle(1);
      end else if (op == 8) begin
        a = $urandom_range(0, 40);
        im_sw_input = $urandom();
        cpu_read(a, rd);
      end else begin
        if ($urandom_range(0, 1) == 0) cpu_write(0, 32'($urandom_range(0, 1)));
        else cpu_write(3, $urandom());
      end
    end
    cpu_write(0, 32'h0);

    cpu_write(1, 32'h456);
    frame_pulse();
    pixel(10, 10, 1'b1);
    pixel(11, 10, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; im_pixel_valid = 1'b0;
    check("rst_mid_rgb", {im_rgb_valid, im_rgb}, 32'h0);
    check("rst_mid_rvalid", 32'(iob_rvalid), 32'h0);
    cpu_read(1, rd);
    check("rst_bg_cleared", rd, 32'h0);
    for (int i = 0; i < N_OBJ; i++) begin
      for (int f = 0; f < 3; f++) begin
        cpu_read(4 + 4 * i + f, rd);
        check("rst_obj_cleared", rd, 32'h0);
      end
    end
    directed_pixel("rst_first_pixel", 10, 10, 12'h000);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
